// File: rtl/scan_mux.sv
// Channel multiplexer with manual select and timed auto-scan.
// Output data, channel index, valid and step are all registered with one cycle of latency.
module scan_mux #(
    parameter  int CHANNELS = 4,
    parameter  int WIDTH    = 1,
    parameter  int DWELL    = 100,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] x,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      hold,
    output logic [WIDTH-1:0]          y,
    output logic [SEL_W-1:0]          ch,
    output logic                      valid,
    output logic                      step
);

    localparam int              CNT_W    = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] y_r;
    logic [SEL_W-1:0] ch_r;
    logic             valid_r;
    logic             step_r;

    logic [CNT_W-1:0] cnt_cur_s;
    logic             terminal_s;
    logic             sel_legal_s;
    logic [SEL_W-1:0] scan_ch_s;

    // Only indices below CHANNELS map to data; anything else yields zero.
    function automatic logic [WIDTH-1:0] pick_channel(
        input logic [CHANNELS*WIDTH-1:0] data,
        input logic [SEL_W-1:0]          idx
    );
        logic [WIDTH-1:0] res;
        res = {WIDTH{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                res = data[k*WIDTH +: WIDTH];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Dwell terminal detection and the channel the scan moves to this cycle.
    always_comb begin
        cnt_cur_s   = (state_r == SCAN) ? cnt_r : {CNT_W{1'b0}};
        terminal_s  = (cnt_cur_s == CNT_LAST);
        sel_legal_s = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));
        if (hold) begin
            scan_ch_s = ch_r;
        end else if (terminal_s) begin
            scan_ch_s = (ch_r == CH_LAST) ? {SEL_W{1'b0}} : ch_r + SEL_W'(1);
        end else begin
            scan_ch_s = ch_r;
        end
    end

    // Mode FSM, dwell counter and registered outputs; mode sampled at an edge governs that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= MANUAL;
            cnt_r   <= {CNT_W{1'b0}};
            y_r     <= {WIDTH{1'b0}};
            ch_r    <= {SEL_W{1'b0}};
            valid_r <= 1'b0;
            step_r  <= 1'b0;
        end else begin
            state_r <= mode ? SCAN : MANUAL;
            if (!mode) begin
                cnt_r  <= {CNT_W{1'b0}};
                step_r <= 1'b0;
                if (sel_legal_s) begin
                    ch_r    <= sel;
                    y_r     <= pick_channel(x, sel);
                    valid_r <= 1'b1;
                end else begin
                    ch_r    <= ch_r;
                    y_r     <= {WIDTH{1'b0}};
                    valid_r <= 1'b0;
                end
            end else begin
                valid_r <= 1'b1;
                ch_r    <= scan_ch_s;
                y_r     <= pick_channel(x, scan_ch_s);
                if (hold) begin
                    cnt_r  <= cnt_cur_s;
                    step_r <= 1'b0;
                end else if (terminal_s) begin
                    cnt_r  <= {CNT_W{1'b0}};
                    step_r <= 1'b1;
                end else begin
                    cnt_r  <= cnt_cur_s + CNT_W'(1);
                    step_r <= 1'b0;
                end
            end
        end
    end

    assign y     = y_r;
    assign ch    = ch_r;
    assign valid = valid_r;
    assign step  = step_r;

endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a reference model queues expected outputs per cycle,
// which are popped and compared after each edge, alongside spot checks of known values.
module tb_scan_mux;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        hold;
    logic [15:0] x;
    logic [1:0]  sel;
    logic [3:0]  y;
    logic [1:0]  ch;
    logic        valid;
    logic        step;

    logic [2:0]  xb;
    logic [1:0]  selb;
    logic [0:0]  yb;
    logic [1:0]  chb;
    logic        validb;
    logic        stepb;

    always #5 clk = ~clk;

    scan_mux #(.CHANNELS(4), .WIDTH(4), .DWELL(3)) dut (
        .clk(clk), .rst(rst), .x(x), .mode(mode), .sel(sel), .hold(hold),
        .y(y), .ch(ch), .valid(valid), .step(step)
    );

    scan_mux #(.CHANNELS(3), .WIDTH(1), .DWELL(3)) dut_b (
        .clk(clk), .rst(rst), .x(xb), .mode(1'b0), .sel(selb), .hold(1'b0),
        .y(yb), .ch(chb), .valid(validb), .step(stepb)
    );

    typedef struct {
        logic [3:0] y;
        logic [1:0] ch;
        logic       valid;
        logic       step;
        string      tag;
    } exp_t;

    exp_t       q[$];
    int         n_vec  = 0;
    int         n_fail = 0;
    int         m_ch   = 0;
    int         m_cnt  = 0;
    logic [3:0] m_y    = 4'h0;
    logic       m_valid = 1'b0;
    logic       m_step  = 1'b0;
    logic [3:0] wrap_y [12];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Advance the reference model with the inputs about to be sampled, then clock and compare.
    task automatic cyc(input string tag);
        exp_t e;
        if (rst) begin
            m_ch = 0; m_cnt = 0; m_y = 4'h0; m_valid = 1'b0; m_step = 1'b0;
        end else if (!mode) begin
            m_cnt = 0; m_step = 1'b0; m_ch = int'(sel); m_valid = 1'b1;
            m_y = x[m_ch*4 +: 4];
        end else begin
            m_valid = 1'b1;
            m_step  = 1'b0;
            if (!hold) begin
                if (m_cnt == 2) begin
                    m_cnt = 0; m_ch = (m_ch + 1) % 4; m_step = 1'b1;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_y = x[m_ch*4 +: 4];
        end
        e.y = m_y; e.ch = 2'(m_ch); e.valid = m_valid; e.step = m_step; e.tag = tag;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check({e.tag, ".y"},     32'(y),     32'(e.y));
        check({e.tag, ".ch"},    32'(ch),    32'(e.ch));
        check({e.tag, ".valid"}, 32'(valid), 32'(e.valid));
        check({e.tag, ".step"},  32'(step),  32'(e.step));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        wrap_y = '{4'hA, 4'hA, 4'hB, 4'hB, 4'hB, 4'hC, 4'hC, 4'hC, 4'hD, 4'hD, 4'hD, 4'hA};
        rst = 1'b1; mode = 1'b1; hold = 1'b0; x = 16'hFFFF; sel = 2'd0;
        xb = 3'b010; selb = 2'd0;

        // Reset dominates a requested scan.
        cyc("rst0");
        cyc("rst1");
        check("rst.y_const", 32'(y), 32'h0);
        check("rst.valid_const", 32'(valid), 32'h0);
        check("rst_b.valid", 32'(validb), 32'h0);
        rst = 1'b0;
        cyc("rel1");
        cyc("rel2");
        check("rel2.step_const", 32'(step), 32'h0);
        cyc("rel3");
        check("rel3.step_const", 32'(step), 32'h1);
        check("rel3.ch_const", 32'(ch), 32'h1);

        // Manual sweep.
        mode = 1'b0; x = 16'h4321;
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            cyc("sweep");
            check("sweep.y_const", 32'(y), 32'(i + 1));
        end

        // Illegal select on the 3-channel instance.
        selb = 2'd2; cyc("b_sel2");
        check("b_sel2.y", 32'(yb), 32'h0);
        check("b_sel2.ch", 32'(chb), 32'h2);
        selb = 2'd3; cyc("b_sel3");
        check("b_sel3.y", 32'(yb), 32'h0);
        check("b_sel3.valid", 32'(validb), 32'h0);
        check("b_sel3.ch", 32'(chb), 32'h2);
        selb = 2'd1; cyc("b_sel1");
        check("b_sel1.y", 32'(yb), 32'h1);
        check("b_sel1.valid", 32'(validb), 32'h1);
        check("b_sel1.ch", 32'(chb), 32'h1);
        check("b.step", 32'(stepb), 32'h0);

        // Scan wrap from channel 0.
        x = 16'hDCBA; sel = 2'd0;
        cyc("wrap_pre");
        mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc("wrap");
            check("wrap.y_const", 32'(y), 32'(wrap_y[i]));
            check("wrap.step_const", 32'(step), (i % 3 == 2) ? 32'h1 : 32'h0);
        end

        // Reach ch=2 with counter=1, then hold with live data changes.
        for (int i = 0; i < 7; i++) cyc("to_hold");
        check("to_hold.ch", 32'(ch), 32'h2);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x[11:8] = 4'(3 + i);
            cyc("hold");
            check("hold.y_const", 32'(y), 32'(3 + i));
            check("hold.ch_const", 32'(ch), 32'h2);
        end
        hold = 1'b0;
        cyc("hold_rel_a");
        check("hold_rel_a.ch", 32'(ch), 32'h2);
        cyc("hold_rel_b");
        check("hold_rel_b.ch", 32'(ch), 32'h3);
        check("hold_rel_b.step", 32'(step), 32'h1);

        // Mode drop coinciding with terminal count.
        cyc("coll0");
        cyc("coll1");
        mode = 1'b0; sel = 2'd1;
        cyc("coll");
        check("coll.step_const", 32'(step), 32'h0);
        check("coll.ch_const", 32'(ch), 32'h1);

        // Hold is ignored in manual mode.
        hold = 1'b1; sel = 2'd2;
        cyc("mhold");
        check("mhold.y_const", 32'(y), 32'h7);
        hold = 1'b0;

        // Reset in the middle of a dwell.
        mode = 1'b1;
        cyc("mid0");
        cyc("mid1");
        rst = 1'b1;
        cyc("mrst");
        check("mrst.ch_const", 32'(ch), 32'h0);
        rst = 1'b0;
        cyc("mrel1");
        cyc("mrel2");
        cyc("mrel3");
        check("mrel3.step_const", 32'(step), 32'h1);
        check("mrel3.ch_const", 32'(ch), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
